// File: rtl/io_bridge.sv
// CPU <-> external word bridge: RXQ (external -> CPU) and TXQ (CPU -> external) FIFOs
// with req/ack CPU channels. Define IO_BRIDGE_STATUS_EN to add rx_count/tx_count/rx_overflow.
//
// state  | meaning
// I_IDLE | waiting for inp_req with RXQ non-empty; pops RXQ on leaving
// I_ACK  | inp_ack pulse, inp_data holds the popped word
// I_DROP | transfer done, waiting for inp_req to fall
// O_IDLE | waiting for out_req with TXQ not full; pushes out_data on leaving
// O_ACK  | out_ack pulse
// O_DROP | transfer done, waiting for out_req to fall
module io_bridge #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   inp_req,
  output logic                   inp_ack,
  output logic [W-1:0]           inp_data,
  input  logic                   out_req,
  input  logic [W-1:0]           out_data,
  output logic                   out_ack,
  input  logic                   ext_in_valid,
  input  logic [W-1:0]           ext_in_data,
  output logic                   ext_in_ready,
  output logic                   ext_out_valid,
  output logic [W-1:0]           ext_out_data,
  input  logic                   ext_out_ready
`ifdef IO_BRIDGE_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic                   rx_overflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {I_IDLE, I_ACK, I_DROP} in_state_t;
  typedef enum logic [1:0] {O_IDLE, O_ACK, O_DROP} out_state_t;

  in_state_t  r_in_state,  w_in_next;
  out_state_t r_out_state, w_out_next;
  logic       w_in_take, w_out_take;

  logic [W-1:0]  r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_wr_ptr, r_rx_rd_ptr;
  logic [CW-1:0] r_rx_count;
  logic          w_rx_push, w_rx_pop;

  logic [W-1:0]  r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_wr_ptr, r_tx_rd_ptr;
  logic [CW-1:0] r_tx_count;
  logic          w_tx_push, w_tx_pop;

  logic [W-1:0]  r_inp_data;

  // ---------------- RXQ ----------------
  assign ext_in_ready = (r_rx_count != FULL);
  assign w_rx_push    = ext_in_valid & ext_in_ready;
  assign w_rx_pop     = w_in_take;

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= ext_in_data;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
    end else begin
      if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + AW'(1);
      if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + AW'(1);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + CW'(1);
        2'b01:   r_rx_count <= r_rx_count - CW'(1);
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // ---------------- TXQ ----------------
  assign ext_out_valid = (r_tx_count != '0);
  assign ext_out_data  = r_tx_mem[r_tx_rd_ptr];
  assign w_tx_pop      = ext_out_valid & ext_out_ready;
  assign w_tx_push     = w_out_take;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= out_data;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
    end else begin
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + AW'(1);
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + AW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + CW'(1);
        2'b01:   r_tx_count <= r_tx_count - CW'(1);
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  // ---------------- CPU input channel ----------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_in_state <= I_IDLE;
      r_inp_data <= '0;
    end else begin
      r_in_state <= w_in_next;
      if (w_rx_pop) r_inp_data <= r_rx_mem[r_rx_rd_ptr];
    end
  end

  always_comb begin
    w_in_next = r_in_state;
    w_in_take = 1'b0;
    case (r_in_state)
      I_IDLE: begin
        if (inp_req && (r_rx_count != '0)) begin
          w_in_take = 1'b1;
          w_in_next = I_ACK;
        end
      end
      I_ACK:   w_in_next = inp_req ? I_DROP : I_IDLE;
      I_DROP:  if (!inp_req) w_in_next = I_IDLE;
      default: w_in_next = I_IDLE;
    endcase
  end

  assign inp_ack  = (r_in_state == I_ACK);
  assign inp_data = r_inp_data;

  // ---------------- CPU output channel ----------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_out_state <= O_IDLE;
    else        r_out_state <= w_out_next;
  end

  always_comb begin
    w_out_next = r_out_state;
    w_out_take = 1'b0;
    case (r_out_state)
      O_IDLE: begin
        if (out_req && (r_tx_count != FULL)) begin
          w_out_take = 1'b1;
          w_out_next = O_ACK;
        end
      end
      O_ACK:   w_out_next = out_req ? O_DROP : O_IDLE;
      O_DROP:  if (!out_req) w_out_next = O_IDLE;
      default: w_out_next = O_IDLE;
    endcase
  end

  assign out_ack = (r_out_state == O_ACK);

`ifdef IO_BRIDGE_STATUS_EN
  logic r_rx_overflow;

  // Sticky: an offered word was refused because RXQ was full.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                          r_rx_overflow <= 1'b0;
    else if (ext_in_valid && !ext_in_ready) r_rx_overflow <= 1'b1;
  end

  assign rx_count    = r_rx_count;
  assign tx_count    = r_tx_count;
  assign rx_overflow = r_rx_overflow;
`endif

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations (status ports when IO_BRIDGE_STATUS_EN).
module tb_io_bridge;
  localparam int DEPTH = 4;
  localparam int W     = 16;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          inp_req = 1'b0;
  logic          inp_ack;
  logic [W-1:0]  inp_data;
  logic          out_req = 1'b0;
  logic [W-1:0]  out_data = '0;
  logic          out_ack;
  logic          ext_in_valid = 1'b0;
  logic [W-1:0]  ext_in_data = '0;
  logic          ext_in_ready;
  logic          ext_out_valid;
  logic [W-1:0]  ext_out_data;
  logic          ext_out_ready = 1'b0;
`ifdef IO_BRIDGE_STATUS_EN
  logic [CW-1:0] rx_count;
  logic [CW-1:0] tx_count;
  logic          rx_overflow;
`endif

  int n_pass  = 0;
  int n_total = 0;

  io_bridge #(.DEPTH(DEPTH), .W(W)) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .inp_req       (inp_req),
    .inp_ack       (inp_ack),
    .inp_data      (inp_data),
    .out_req       (out_req),
    .out_data      (out_data),
    .out_ack       (out_ack),
    .ext_in_valid  (ext_in_valid),
    .ext_in_data   (ext_in_data),
    .ext_in_ready  (ext_in_ready),
    .ext_out_valid (ext_out_valid),
    .ext_out_data  (ext_out_data),
    .ext_out_ready (ext_out_ready)
`ifdef IO_BRIDGE_STATUS_EN
    ,
    .rx_count      (rx_count),
    .tx_count      (tx_count),
    .rx_overflow   (rx_overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: FIFOs as queues, one transfer per held-request interval.
  logic [W-1:0] m_rxq[$];
  logic [W-1:0] m_txq[$];
  logic [W-1:0] m_inp_data = '0;
  bit m_in_served, m_out_served, m_inp_ack, m_out_ack, m_ovf;
  bit mr_take, mr_push, mt_take, mt_pop;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_rxq.delete();
      m_txq.delete();
      m_inp_data   = '0;
      m_in_served  = 0;
      m_out_served = 0;
      m_inp_ack    = 0;
      m_out_ack    = 0;
      m_ovf        = 0;
    end else begin
      if (ext_in_valid && m_rxq.size() == DEPTH) m_ovf = 1;
      mr_take = inp_req && !m_in_served && (m_rxq.size() != 0);
      mr_push = ext_in_valid && (m_rxq.size() != DEPTH);
      mt_take = out_req && !m_out_served && (m_txq.size() != DEPTH);
      mt_pop  = ext_out_ready && (m_txq.size() != 0);
      if (mr_take) m_inp_data = m_rxq.pop_front();
      if (mr_push) m_rxq.push_back(ext_in_data);
      if (mt_pop)  void'(m_txq.pop_front());
      if (mt_take) m_txq.push_back(out_data);
      m_inp_ack    = mr_take;
      m_out_ack    = mt_take;
      m_in_served  = mr_take || (inp_req && m_in_served);
      m_out_served = mt_take || (out_req && m_out_served);
    end
  end

  always @(negedge clk) begin
    chk("m_inp_ack",       32'(inp_ack),       32'(m_inp_ack));
    chk("m_inp_data",      32'(inp_data),      32'(m_inp_data));
    chk("m_out_ack",       32'(out_ack),       32'(m_out_ack));
    chk("m_ext_in_ready",  32'(ext_in_ready),  32'(m_rxq.size() != DEPTH));
    chk("m_ext_out_valid", 32'(ext_out_valid), 32'(m_txq.size() != 0));
    if (m_txq.size() != 0) chk("m_ext_out_data", 32'(ext_out_data), 32'(m_txq[0]));
`ifdef IO_BRIDGE_STATUS_EN
    chk("m_rx_count",    32'(rx_count),    32'(m_rxq.size()));
    chk("m_tx_count",    32'(tx_count),    32'(m_txq.size()));
    chk("m_rx_overflow", 32'(rx_overflow), 32'(m_ovf));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_push(input logic [W-1:0] d);
    ext_in_valid = 1'b1;
    ext_in_data  = d;
    tick();
    ext_in_valid = 1'b0;
  endtask

  task automatic cpu_read(output logic [W-1:0] d);
    bit ok = 0;
    d = '0;
    inp_req = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      if (inp_ack) begin
        ok = 1;
        d  = inp_data;
      end
    end
    inp_req = 1'b0;
    chk("cpu_read_ack", 32'(ok), 32'd1);
  endtask

  task automatic cpu_write(input logic [W-1:0] d);
    bit ok = 0;
    out_req  = 1'b1;
    out_data = d;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      if (out_ack) ok = 1;
    end
    out_req = 1'b0;
    chk("cpu_write_ack", 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] tw [5];
    int acks;
    tw = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

    repeat (3) tick();
    chk("rst_inp_data", 32'(inp_data), 32'h0);
    chk("rst_in_ready", 32'(ext_in_ready), 32'd1);
    chk("rst_out_valid", 32'(ext_out_valid), 32'd0);
    rst_b = 1'b1;
    tick();

    // Two words in, request held three cycles -> single ack with the first word
    ext_push(16'h1234);
    ext_push(16'hABCD);
    inp_req = 1'b1;
    acks = 0;
    d = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (inp_ack) begin
        acks++;
        d = inp_data;
      end
    end
    inp_req = 1'b0;
    tick();
    tick();
    chk("held_req_one_ack", 32'(acks), 32'd1);
    chk("first_word", 32'(d), 32'h1234);
    cpu_read(d);
    chk("second_word", 32'(d), 32'hABCD);
    tick();

    // Request waits on empty RXQ, then ack one cycle after the push edge
    inp_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (inp_ack) acks++;
    end
    chk("no_ack_while_empty", 32'(acks), 32'd0);
    ext_in_valid = 1'b1;
    ext_in_data  = 16'h0042;
    tick();
    ext_in_valid = 1'b0;
    chk("no_ack_at_push_edge", 32'(inp_ack), 32'd0);
    tick();
    chk("ack_after_push", 32'(inp_ack), 32'd1);
    chk("waited_word", 32'(inp_data), 32'h0042);
    inp_req = 1'b0;
    tick();

    // TXQ fill with consumer stalled, fifth request held until one pop
    for (int i = 0; i < 4; i++) begin
      cpu_write(tw[i]);
      tick();
    end
    out_req  = 1'b1;
    out_data = tw[4];
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_ack) acks++;
    end
    chk("fifth_held", 32'(acks), 32'd0);
    chk("head_before_pop", 32'(ext_out_data), 32'h1111);
    ext_out_ready = 1'b1;
    tick();
    ext_out_ready = 1'b0;
    chk("fifth_not_at_pop", 32'(out_ack), 32'd0);
    tick();
    chk("fifth_ack", 32'(out_ack), 32'd1);
    out_req = 1'b0;
    ext_out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk("tx_order", 32'(ext_out_data), 32'(tw[i]));
      tick();
    end
    ext_out_ready = 1'b0;
    chk("tx_drained", 32'(ext_out_valid), 32'd0);

    // RXQ full: CPU pop and external offer in the same cycle
    ext_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ext_in_data = 16'h0A01 + 16'(i);
      tick();
    end
    chk("rx_full_ready", 32'(ext_in_ready), 32'd0);
`ifdef IO_BRIDGE_STATUS_EN
    chk("rx_count_full", 32'(rx_count), 32'd4);
`endif
    ext_in_data = 16'h0A05;
    inp_req = 1'b1;
    tick();
    chk("pop_ack", 32'(inp_ack), 32'd1);
    chk("pop_word", 32'(inp_data), 32'h0A01);
    chk("ready_after_pop", 32'(ext_in_ready), 32'd1);
`ifdef IO_BRIDGE_STATUS_EN
    chk("rx_count_3", 32'(rx_count), 32'd3);
`endif
    inp_req = 1'b0;
    tick();
    ext_in_valid = 1'b0;
    chk("rx_refull_ready", 32'(ext_in_ready), 32'd0);
`ifdef IO_BRIDGE_STATUS_EN
    chk("rx_overflow_set", 32'(rx_overflow), 32'd1);
    chk("rx_count_refull", 32'(rx_count), 32'd4);
`endif
    for (int i = 1; i < 5; i++) begin
      cpu_read(d);
      chk("rx_order", 32'(d), 32'h0A01 + 32'(i));
      tick();
    end
`ifdef IO_BRIDGE_STATUS_EN
    chk("rx_overflow_sticky", 32'(rx_overflow), 32'd1);
    chk("rx_count_empty", 32'(rx_count), 32'd0);
`endif

    // Mixed concurrent traffic, checked by the model
    for (int i = 0; i < 60; i++) begin
      ext_in_valid  = (i % 3) != 0;
      ext_in_data   = 16'h0100 + 16'(i);
      ext_out_ready = (i % 4) < 2;
      if (inp_req && inp_ack) inp_req = 1'b0;
      else if (!inp_req && (i % 5) != 4) inp_req = 1'b1;
      if (out_req && out_ack) out_req = 1'b0;
      else if (!out_req && (i % 7) != 6) begin
        out_req  = 1'b1;
        out_data = 16'hC000 + 16'(i);
      end
      tick();
    end
    inp_req = 1'b0;
    out_req = 1'b0;
    ext_in_valid = 1'b0;
    ext_out_ready = 1'b1;
    repeat (8) tick();
    ext_out_ready = 1'b0;
    ext_in_valid = 1'b1;
    ext_in_data  = 16'h00EE;
    repeat (DEPTH + 2) tick();
    ext_in_valid = 1'b0;
    chk("prereset_rx_full", 32'(ext_in_ready), 32'd0);

    // Reset mid-cycle while both acks are up
    out_req  = 1'b1;
    out_data = 16'h7777;
    inp_req  = 1'b1;
    tick();
    chk("prerst_inp_ack", 32'(inp_ack), 32'd1);
    chk("prerst_out_ack", 32'(out_ack), 32'd1);
    chk("prerst_out_valid", 32'(ext_out_valid), 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_inp_ack", 32'(inp_ack), 32'd0);
    chk("arst_out_ack", 32'(out_ack), 32'd0);
    chk("arst_out_valid", 32'(ext_out_valid), 32'd0);
    chk("arst_in_ready", 32'(ext_in_ready), 32'd1);
    chk("arst_inp_data", 32'(inp_data), 32'h0);
    inp_req = 1'b0;
    out_req = 1'b0;
    tick();
    tick();
    rst_b = 1'b1;
    tick();
    chk("postrst_in_ready", 32'(ext_in_ready), 32'd1);
    chk("postrst_out_valid", 32'(ext_out_valid), 32'd0);
`ifdef IO_BRIDGE_STATUS_EN
    chk("postrst_overflow", 32'(rx_overflow), 32'd0);
`endif
    ext_push(16'h5A5A);
    cpu_read(d);
    chk("postrst_word", 32'(d), 32'h5A5A);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving words per FIFO; legal values 2, 4, 8, 16.
REQ-002 SHALL have parameter W, default 16, giving the data word width.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_b  input  1  reset, asynchronous assert, active-low.
REQ-005 inp_req  input  1  CPU requests one input word; held high until inp_ack is seen.
REQ-006 inp_ack  output  1  one-cycle pulse; inp_data is valid in the same cycle.
REQ-007 inp_data  output  W  input word returned to the CPU.
REQ-008 out_req  input  1  CPU offers out_data; held high until out_ack is seen.
REQ-009 out_data  input  W  word from the CPU.
REQ-010 out_ack  output  1  one-cycle pulse: word accepted.
REQ-011 ext_in_valid / ext_in_data[W] / ext_in_ready  in/in/out  external producer, valid-ready.
REQ-012 ext_out_valid / ext_out_data[W] / ext_out_ready  out/out/in  external consumer, valid-ready.

Function
REQ-013 SHALL contain two independent FIFOs of DEPTH words: RXQ (external to CPU) and TXQ (CPU to external).
- Each FIFO has a read pointer, a write pointer and a count of width log2(DEPTH)+1.
- Pointers wrap modulo DEPTH.
REQ-014 RXQ push: when ext_in_valid & ext_in_ready.
- ext_in_ready = (RXQ count != DEPTH), combinational from registered state.
REQ-015 TXQ pop: when ext_out_valid & ext_out_ready.
- ext_out_valid = (TXQ count != 0).
- ext_out_data = TXQ head word; combinational, registered storage.
REQ-016 CPU input channel SHALL be an FSM with states I_IDLE, I_ACK, I_DROP.
- I_IDLE -> I_ACK when inp_req=1 and RXQ is not empty at the clock edge; pop RXQ on that edge and register the head into inp_data.
- I_ACK lasts one cycle: inp_ack=1. Next state is I_DROP if inp_req=1, else I_IDLE.
- I_DROP -> I_IDLE when inp_req=0.
- Latency: inp_ack rises 1 cycle after the req edge when data is present; it waits indefinitely while RXQ is empty.
REQ-017 CPU output channel SHALL be an FSM with states O_IDLE, O_ACK, O_DROP, with the same transitions.
- Sampled on out_req and TXQ not full; push out_data on the transition edge.
REQ-018 Each request-held interval SHALL produce exactly one ack and one FIFO transfer, so no double pop or push.
REQ-019 Simultaneous push and pop on one FIFO SHALL leave count unchanged and both SHALL take effect.
- RXQ full: the CPU pop frees space, but ext_in_ready SHALL still be 0 that cycle.
- TXQ empty: the CPU push SHALL NOT be visible on ext_out_valid until the next cycle.
REQ-020 inp_data SHALL hold its last value outside I_ACK.

Reset
REQ-021 On rst_b=0, asynchronously:
- FSMs go to I_IDLE and O_IDLE; pointers and counts go to 0.
- inp_ack=0, out_ack=0, inp_data=0.
- ext_out_valid=0; ext_in_ready=1 after the count clears.
REQ-022 Reset mid-handshake SHALL drop any acknowledged-but-unseen transfer; FIFO contents are discarded.

Configuration
REQ-023 Macro IO_BRIDGE_STATUS_EN defined: SHALL add the following outputs.
- rx_count, tx_count (log2(DEPTH)+1 bits, current counts).
- rx_overflow (sticky; set when ext_in_valid=1 while RXQ full; cleared only by reset).
REQ-024 Macro IO_BRIDGE_STATUS_EN undefined: these ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-025 Reset: rst_b low mid-cycle -> inp_ack=0, out_ack=0, ext_out_valid=0, ext_in_ready=1 with no clock edge.
REQ-026 External push of 0x1234 and 0xABCD, then inp_req held 3 cycles -> exactly one inp_ack, with inp_data=0x1234.
- A second req -> inp_data=0xABCD.
REQ-027 inp_req with RXQ empty for 10 cycles, then push 0x0042 -> inp_ack 1 cycle after the push edge, with inp_data=0x0042.
REQ-028 TXQ fill, DEPTH=4, ext_out_ready=0: four out_req transfers -> four out_acks.
- The fifth out_req is held with no ack.
- Raise ext_out_ready for 1 cycle -> the fifth ack follows, and ext_out_data order = first-in first.
REQ-029 RXQ full while the CPU pops and ext_in_valid=1 in the same cycle -> count 4→3, ext_in_ready=0 that cycle, ready=1 the next.
REQ-030 With IO_BRIDGE_STATUS_EN: push 5 words with DEPTH=4 and no pops -> rx_overflow=1 and rx_count=4; rx_overflow stays 1 after draining.
